// File: rtl/req_arbiter8.sv
// Eight-way round-robin arbiter for a shared resource. Holds one registered
// grant until the resource signals completion or the BUSY timeout expires.
module req_arbiter8 #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] req_mask,
    input  logic       rsp_done,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_n;
    logic [2:0]       ptr, ptr_n;
    logic [CNT_W-1:0] count, count_n;
    logic [7:0]       grant_n;
    logic [2:0]       sel_n;
    logic             busy_n;
    logic             timeout_n;

    logic [7:0]       elig;
    logic [2:0]       search_start;
    logic             win_found;
    logic [2:0]       win_idx;
    logic             release_now;

    // First eligible index at or above start, wrapping modulo 8.
    function automatic logic [3:0] find_winner(input logic [7:0] v, input logic [2:0] start);
        logic       found;
        logic [2:0] idx;
        logic [2:0] cand;
        found = 1'b0;
        idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            cand = start + 3'(i);
            if (!found && v[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    assign elig        = req & ~req_mask;
    assign release_now = (state == BUSY) && (rsp_done || (count == CNT_LAST));

    // A releasing requester drops to lowest priority, so search starts past it.
    assign search_start = release_now ? (sel + 3'd1) : ptr;
    assign {win_found, win_idx} = find_winner(elig, search_start);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_n   = state;
        ptr_n     = ptr;
        count_n   = count;
        grant_n   = grant;
        sel_n     = sel;
        busy_n    = busy;
        timeout_n = 1'b0;

        unique case (state)
            IDLE: begin
                if (win_found) begin
                    state_n = BUSY;
                    grant_n = 8'(1) << win_idx;
                    sel_n   = win_idx;
                    busy_n  = 1'b1;
                    count_n = '0;
                end
            end
            BUSY: begin
                if (release_now) begin
                    ptr_n     = sel + 3'd1;
                    timeout_n = !rsp_done;
                    count_n   = '0;
                    if (win_found) begin
                        grant_n = 8'(1) << win_idx;
                        sel_n   = win_idx;
                    end else begin
                        state_n = IDLE;
                        grant_n = '0;
                        busy_n  = 1'b0;
                    end
                end else begin
                    count_n = count + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            count   <= '0;
            grant   <= '0;
            sel     <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            count   <= count_n;
            grant   <= grant_n;
            sel     <= sel_n;
            busy    <= busy_n;
            timeout <= timeout_n;
        end
    end

endmodule
